axi_modport: RTL and testbench
==============================

AXI_MODPORT -- requirements
Module: axi_modport

Interface
- REQ-001 SHALL have parameter ID_WIDTH, default 4, AXI ID width.
- REQ-002 SHALL have parameter ADDR_WIDTH, default 16, byte address width.
- REQ-003 SHALL have parameter DATA_WIDTH, default 32, data bus width (32 or 64).
- REQ-004 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, byte strobe width.
- REQ-005 SHALL have parameter MEM_WORDS, default 256, memory depth in bus words (power of two).
- REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
- REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-008 SHALL have AW inputs s_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid, widths ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/1; output s_axi_awready, 1 bit.
- REQ-009 SHALL have W inputs s_axi_wdata DATA_WIDTH, s_axi_wstrb STRB_WIDTH, s_axi_wlast 1, s_axi_wvalid 1; output s_axi_wready, 1 bit.
- REQ-010 SHALL have B outputs s_axi_bid ID_WIDTH, s_axi_bresp 2, s_axi_bvalid 1; input s_axi_bready, 1 bit.
- REQ-011 SHALL have AR inputs mirroring AW (s_axi_arid ... s_axi_arvalid, same widths); output s_axi_arready, 1 bit.
- REQ-012 SHALL have R outputs s_axi_rid ID_WIDTH, s_axi_rdata DATA_WIDTH, s_axi_rresp 2, s_axi_rlast 1, s_axi_rvalid 1; input s_axi_rready, 1 bit.

Function
- REQ-013 SHALL implement an AXI4 slave backed by MEM_WORDS x DATA_WIDTH RAM; word index = (addr >> log2(STRB_WIDTH)) mod MEM_WORDS.
- REQ-014 SHALL ignore lock, cache and prot.
- REQ-015 Write FSM SHALL be W_IDLE (awready=1) -> on AW handshake capture id/addr/len/size/burst -> W_DATA (wready=1) -> after beat awlen+1 accepted -> W_RESP (bvalid=1) -> on bready -> W_IDLE.
- REQ-016 Each accepted W beat SHALL write only bytes whose wstrb bit is 1; data visible to reads from the next cycle.
- REQ-017 Burst SHALL end on beat count awlen+1 regardless of wlast; wlast mismatch on any beat SHALL give bresp=SLVERR (2'b10), data still written.
- REQ-018 Address step per beat: FIXED (0) none; INCR (1) +2^size; WRAP (2) +2^size wrapping within a (len+1)*2^size aligned window; reserved (3) SHALL give SLVERR with no memory writes / zero read data.
- REQ-019 size greater than log2(STRB_WIDTH) SHALL give SLVERR, no writes, read data zero.
- REQ-020 bid SHALL equal captured awid; bresp OKAY (2'b00) otherwise.
- REQ-021 Read FSM SHALL be R_IDLE (arready=1) -> AR handshake -> R_DATA: rvalid=1 from the next cycle, rdata registered, each beat held until rready, next beat one cycle after handshake with no bubble; rlast=1 on beat arlen+1; return to R_IDLE after last handshake.
- REQ-022 rid SHALL equal captured arid; rresp per beat as REQ-018/019, else OKAY.
- REQ-023 Read and write channels SHALL run concurrently and independently; one outstanding transaction per direction.
- REQ-024 Simultaneous write and read of one word in one cycle: read SHALL return the old contents.
- REQ-025 Addresses beyond memory SHALL wrap modulo MEM_WORDS, never error.

Reset
- REQ-026 While rst=1 all outputs SHALL be 0 and both FSMs SHALL be forced idle, aborting any burst mid-operation.
- REQ-027 First cycle after rst deasserts, awready and arready SHALL be 1.
- REQ-028 Memory contents SHALL NOT be reset.

Configuration
- REQ-029 With macro AXI_MODPORT_WRAP_EN defined, WRAP bursts SHALL behave per REQ-018.
- REQ-030 Without AXI_MODPORT_WRAP_EN, WRAP SHALL be treated as reserved burst type (SLVERR, no writes, zero read data).

Verification
- REQ-031 INCR write awaddr=0x10 awlen=3 size=2 data 1,2,3,4 strb=F, then same read -> bresp=0, rdata 1,2,3,4, rlast on 4th beat, ids echoed.
- REQ-032 Write 0xAABBCCDD then wstrb=4'b0101 data 0x11223344 to 0x20; read -> 0xAA22CC44.
- REQ-033 WRAP awaddr=0x08 awlen=3 size=2, define set -> beats at 0x08,0x0C,0x00,0x04; undefined -> bresp=2.
- REQ-034 awsize=3 on 32-bit bus, or wlast high on beat 1 of 2 -> bresp=2'b10.
- REQ-035 rready low 3 cycles during read beat 2 -> rdata/rvalid stable, no beat lost.
- REQ-036 rst pulsed mid-write burst -> all outputs 0 during reset, awready=1 next cycle, new burst completes normally.

Source files
------------

// File: rtl/axi_modport.sv
// AXI4 slave backed by a byte-strobed RAM, with independent read and write FSMs.
// Define AXI_MODPORT_WRAP_EN to support WRAP bursts; otherwise WRAP is answered as reserved.
module axi_modport #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned MEM_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int unsigned OFF   = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
`ifdef AXI_MODPORT_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic [0:0] {RIdle, RData} r_state_e;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0] size,
                                                      input logic [7:0] len,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] nxt;
    step = ADDR_WIDTH'(1) << size;
    // Wrap window is (len+1) beats of 2^size bytes, aligned to its own size
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      2'd1:    nxt = a + step;
      2'd2:    nxt = (a & ~mask) | ((a + step) & mask);
      default: nxt = a;
    endcase
    return nxt;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] w;
    w = a >> OFF;
    return w[IDX_W-1:0];
  endfunction

  function automatic logic bad_xfer(input logic [2:0] size, input logic [1:0] burst);
    return (size > 3'(OFF)) || (burst == 2'd3) || ((burst == 2'd2) && !WRAP_EN);
  endfunction

  // ---------------- write channel ----------------
  w_state_e              w_state_q;
  logic [ID_WIDTH-1:0]   w_id_q;
  logic [ADDR_WIDTH-1:0] w_addr_q;
  logic [7:0]            w_len_q;
  logic [7:0]            w_cnt_q;
  logic [2:0]            w_size_q;
  logic [1:0]            w_burst_q;
  logic                  w_bad_q;
  logic                  w_err_q;
  logic [1:0]            bresp_q;
  logic                  w_fire;

  assign s_axi_awready = (w_state_q == WIdle) && !rst;
  assign s_axi_wready  = (w_state_q == WData) && !rst;
  assign s_axi_bvalid  = (w_state_q == WResp) && !rst;
  assign s_axi_bid     = w_id_q;
  assign s_axi_bresp   = bresp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= WIdle;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_bad_q   <= 1'b0;
      w_err_q   <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      case (w_state_q)
        WIdle: if (s_axi_awvalid) begin
          w_id_q    <= s_axi_awid;
          w_addr_q  <= s_axi_awaddr;
          w_len_q   <= s_axi_awlen;
          w_size_q  <= s_axi_awsize;
          w_burst_q <= s_axi_awburst;
          w_bad_q   <= bad_xfer(s_axi_awsize, s_axi_awburst);
          w_err_q   <= 1'b0;
          w_cnt_q   <= '0;
          w_state_q <= WData;
        end
        WData: if (s_axi_wvalid) begin
          w_addr_q <= next_addr(w_addr_q, w_size_q, w_len_q, w_burst_q);
          w_cnt_q  <= w_cnt_q + 8'd1;
          // Beat count, not wlast, terminates the burst
          if (w_cnt_q == w_len_q) begin
            bresp_q   <= (w_bad_q || w_err_q || !s_axi_wlast) ? 2'b10 : 2'b00;
            w_state_q <= WResp;
          end else if (s_axi_wlast) begin
            w_err_q <= 1'b1;
          end
        end
        WResp: if (s_axi_bready) begin
          bresp_q   <= 2'b00;
          w_state_q <= WIdle;
        end
        default: w_state_q <= WIdle;
      endcase
    end
  end

  assign w_fire = s_axi_wready && s_axi_wvalid && !w_bad_q;

  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int b = 0; b < int'(STRB_WIDTH); b++) begin
        if (s_axi_wstrb[b]) mem[word_idx(w_addr_q)][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_e              r_state_q;
  logic [ID_WIDTH-1:0]   r_id_q;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [7:0]            r_len_q;
  logic [7:0]            r_cnt_q;
  logic [2:0]            r_size_q;
  logic [1:0]            r_burst_q;
  logic                  r_bad_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  rlast_q;
  logic                  ar_bad;

  assign ar_bad        = bad_xfer(s_axi_arsize, s_axi_arburst);
  assign s_axi_arready = (r_state_q == RIdle) && !rst;
  assign s_axi_rvalid  = (r_state_q == RData) && !rst;
  assign s_axi_rid     = r_id_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= RIdle;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_bad_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
    end else begin
      case (r_state_q)
        RIdle: if (s_axi_arvalid) begin
          r_id_q    <= s_axi_arid;
          r_len_q   <= s_axi_arlen;
          r_size_q  <= s_axi_arsize;
          r_burst_q <= s_axi_arburst;
          r_bad_q   <= ar_bad;
          r_cnt_q   <= '0;
          r_addr_q  <= next_addr(s_axi_araddr, s_axi_arsize, s_axi_arlen, s_axi_arburst);
          rdata_q   <= ar_bad ? '0 : mem[word_idx(s_axi_araddr)];
          rresp_q   <= ar_bad ? 2'b10 : 2'b00;
          rlast_q   <= (s_axi_arlen == 8'd0);
          r_state_q <= RData;
        end
        RData: if (s_axi_rready) begin
          if (rlast_q) begin
            rlast_q   <= 1'b0;
            r_state_q <= RIdle;
          end else begin
            // Prefetch the following beat so it is valid on the next cycle
            rdata_q  <= r_bad_q ? '0 : mem[word_idx(r_addr_q)];
            r_addr_q <= next_addr(r_addr_q, r_size_q, r_len_q, r_burst_q);
            r_cnt_q  <= r_cnt_q + 8'd1;
            rlast_q  <= ((r_cnt_q + 8'd1) == r_len_q);
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

  logic unused;
  assign unused = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot,
                    s_axi_arlock, s_axi_arcache, s_axi_arprot};

endmodule

// File: tb/tb_axi_modport.sv
// Directed self-checking bench for axi_modport (32-bit bus, 256 words).
module tb_axi_modport;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awid, arid, bid, rid;
  logic [15:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awlock, arlock, awvalid, arvalid, awready, arready;
  logic [3:0]  awcache, arcache, wstrb;
  logic [31:0] wdata, rdata;
  logic        wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi_modport #(
    .ID_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .STRB_WIDTH(4), .MEM_WORDS(256)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(awlock), .s_axi_awcache(awcache),
    .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(arlock), .s_axi_arcache(arcache),
    .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic        wl [16];
  logic [31:0] rd [16];
  logic [1:0]  rr [16];
  logic        rl [16];
  logic [3:0]  rid_got;
  logic [1:0]  resp;
  logic [3:0]  bid_got;

  task automatic prep(input int len, input logic [31:0] base);
    for (int i = 0; i < 16; i++) begin
      wd[i] = base + 32'(i);
      ws[i] = 4'hF;
      wl[i] = (i == len);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic axi_write(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id,
                           output logic [1:0] r, output logic [3:0] b);
    int t;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 100) begin @(negedge clk); t++; end
    if (!awready) check_eq("aw_timeout", 64'(awready), 64'(1));
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = wl[i]; wvalid = 1'b1;
      t = 0;
      while (!wready && t < 100) begin @(negedge clk); t++; end
      if (!wready) check_eq("w_timeout", 64'(wready), 64'(1));
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    t = 0;
    while (!bvalid && t < 100) begin @(negedge clk); t++; end
    if (!bvalid) check_eq("b_timeout", 64'(bvalid), 64'(1));
    r = bresp; b = bid;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id,
                          input int stall, input logic [31:0] stall_exp);
    int t;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 100) begin @(negedge clk); t++; end
    if (!arready) check_eq("ar_timeout", 64'(arready), 64'(1));
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      while (!rvalid && t < 100) begin @(negedge clk); t++; end
      if (!rvalid) check_eq("r_timeout", 64'(rvalid), 64'(1));
      rd[i] = rdata; rr[i] = rresp; rl[i] = rlast; rid_got = rid;
      if (i == stall) begin
        rready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check_eq("stall_rdata", 64'(rdata), 64'(stall_exp));
          check_eq("stall_rvalid", 64'(rvalid), 64'(1));
        end
        rready = 1'b1;
      end
      @(negedge clk);
    end
    rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = 1'b0;
    awcache = '0; awprot = '0; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = 1'b0;
    arcache = '0; arprot = '0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_awready", 64'(awready), 64'(0));
    check_eq("rst_arready", 64'(arready), 64'(0));
    check_eq("rst_wready", 64'(wready), 64'(0));
    check_eq("rst_bvalid", 64'(bvalid), 64'(0));
    check_eq("rst_rvalid", 64'(rvalid), 64'(0));
    check_eq("rst_rdata", 64'(rdata), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_awready", 64'(awready), 64'(1));
    check_eq("post_rst_arready", 64'(arready), 64'(1));

    // INCR write/read with ids echoed
    prep(3, 32'd1);
    axi_write(16'h0010, 8'd3, 3'd2, 2'd1, 4'h5, resp, bid_got);
    check_eq("incr_bresp", 64'(resp), 64'(0));
    check_eq("incr_bid", 64'(bid_got), 64'(5));
    axi_read(16'h0010, 8'd3, 3'd2, 2'd1, 4'h9, -1, 32'd0);
    check_eq("incr_rid", 64'(rid_got), 64'(9));
    for (int i = 0; i < 4; i++) begin
      check_eq("incr_rdata", 64'(rd[i]), 64'(i + 1));
      check_eq("incr_rlast", 64'(rl[i]), 64'(i == 3));
      check_eq("incr_rresp", 64'(rr[i]), 64'(0));
    end

    // rready stall on beat 2
    axi_read(16'h0010, 8'd3, 3'd2, 2'd1, 4'h3, 1, 32'd2);
    for (int i = 0; i < 4; i++) check_eq("stall_beat", 64'(rd[i]), 64'(i + 1));

    // Byte strobes
    prep(0, 32'hAABBCCDD);
    axi_write(16'h0020, 8'd0, 3'd2, 2'd1, 4'h1, resp, bid_got);
    prep(0, 32'h11223344);
    ws[0] = 4'b0101;
    axi_write(16'h0020, 8'd0, 3'd2, 2'd1, 4'h1, resp, bid_got);
    axi_read(16'h0020, 8'd0, 3'd2, 2'd1, 4'h1, -1, 32'd0);
    check_eq("strb_rdata", 64'(rd[0]), 64'hAA22CC44);

    // WRAP burst
    prep(3, 32'hA0);
    axi_write(16'h0000, 8'd3, 3'd2, 2'd1, 4'h2, resp, bid_got);
    prep(3, 32'hB0);
    axi_write(16'h0008, 8'd3, 3'd2, 2'd2, 4'h2, resp, bid_got);
    axi_read(16'h0000, 8'd3, 3'd2, 2'd1, 4'h2, -1, 32'd0);
`ifdef AXI_MODPORT_WRAP_EN
    check_eq("wrap_bresp", 64'(resp), 64'(0));
    check_eq("wrap_mem0", 64'(rd[0]), 64'hB2);
    check_eq("wrap_mem1", 64'(rd[1]), 64'hB3);
    check_eq("wrap_mem2", 64'(rd[2]), 64'hB0);
    check_eq("wrap_mem3", 64'(rd[3]), 64'hB1);
    axi_read(16'h0008, 8'd3, 3'd2, 2'd2, 4'h2, -1, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_eq("wrap_rdata", 64'(rd[i]), 64'(32'hB0 + 32'(i)));
      check_eq("wrap_rresp", 64'(rr[i]), 64'(0));
    end
`else
    check_eq("wrap_bresp", 64'(resp), 64'(2));
    for (int i = 0; i < 4; i++) check_eq("wrap_nowrite", 64'(rd[i]), 64'(32'hA0 + 32'(i)));
    axi_read(16'h0008, 8'd3, 3'd2, 2'd2, 4'h2, -1, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_eq("wrap_rdata", 64'(rd[i]), 64'(0));
      check_eq("wrap_rresp", 64'(rr[i]), 64'(2));
    end
`endif

    // Oversized transfer
    prep(0, 32'h12345678);
    axi_write(16'h0040, 8'd0, 3'd2, 2'd1, 4'h4, resp, bid_got);
    prep(0, 32'h55555555);
    axi_write(16'h0040, 8'd0, 3'd3, 2'd1, 4'h4, resp, bid_got);
    check_eq("size_bresp", 64'(resp), 64'(2));
    axi_read(16'h0040, 8'd0, 3'd2, 2'd1, 4'h4, -1, 32'd0);
    check_eq("size_nowrite", 64'(rd[0]), 64'h12345678);
    axi_read(16'h0040, 8'd0, 3'd3, 2'd1, 4'h4, -1, 32'd0);
    check_eq("size_rresp", 64'(rr[0]), 64'(2));
    check_eq("size_rdata", 64'(rd[0]), 64'(0));

    // Early wlast: error response, data still written
    prep(1, 32'hC1);
    wl[0] = 1'b1;
    axi_write(16'h0050, 8'd1, 3'd2, 2'd1, 4'h6, resp, bid_got);
    check_eq("wlast_bresp", 64'(resp), 64'(2));
    axi_read(16'h0050, 8'd1, 3'd2, 2'd1, 4'h6, -1, 32'd0);
    check_eq("wlast_data0", 64'(rd[0]), 64'hC1);
    check_eq("wlast_data1", 64'(rd[1]), 64'hC2);

    // Reserved burst type on read
    axi_read(16'h0050, 8'd0, 3'd2, 2'd3, 4'h6, -1, 32'd0);
    check_eq("rsvd_rresp", 64'(rr[0]), 64'(2));
    check_eq("rsvd_rdata", 64'(rd[0]), 64'(0));

    // FIXED burst: every beat hits the same word
    prep(2, 32'd1);
    axi_write(16'h0060, 8'd2, 3'd2, 2'd0, 4'h7, resp, bid_got);
    check_eq("fixed_bresp", 64'(resp), 64'(0));
    axi_read(16'h0060, 8'd1, 3'd2, 2'd0, 4'h7, -1, 32'd0);
    check_eq("fixed_rdata0", 64'(rd[0]), 64'(3));
    check_eq("fixed_rdata1", 64'(rd[1]), 64'(3));

    // Address beyond memory aliases modulo 1 KiB
    prep(0, 32'h77);
    axi_write(16'h0470, 8'd0, 3'd2, 2'd1, 4'h8, resp, bid_got);
    check_eq("alias_bresp", 64'(resp), 64'(0));
    axi_read(16'h0070, 8'd0, 3'd2, 2'd1, 4'h8, -1, 32'd0);
    check_eq("alias_rdata", 64'(rd[0]), 64'h77);

    // Concurrent write and read on different words
    prep(1, 32'hE0);
    fork
      axi_write(16'h0090, 8'd1, 3'd2, 2'd1, 4'hA, resp, bid_got);
      axi_read(16'h0010, 8'd3, 3'd2, 2'd1, 4'hB, -1, 32'd0);
    join
    check_eq("conc_bresp", 64'(resp), 64'(0));
    check_eq("conc_bid", 64'(bid_got), 64'hA);
    for (int i = 0; i < 4; i++) check_eq("conc_rdata", 64'(rd[i]), 64'(i + 1));
    axi_read(16'h0090, 8'd1, 3'd2, 2'd1, 4'hB, -1, 32'd0);
    check_eq("conc_wr0", 64'(rd[0]), 64'hE0);
    check_eq("conc_wr1", 64'(rd[1]), 64'hE1);

    // Same-cycle write and read of one word returns old contents
    prep(0, 32'h0A0A0A0A);
    axi_write(16'h00A0, 8'd0, 3'd2, 2'd1, 4'h1, resp, bid_got);
    prep(0, 32'h5A5A5A5A);
    fork
      axi_write(16'h00A0, 8'd0, 3'd2, 2'd1, 4'h1, resp, bid_got);
      axi_read(16'h00A0, 8'd1, 3'd2, 2'd0, 4'h1, -1, 32'd0);
    join
    check_eq("rdw_beat0", 64'(rd[0]), 64'h0A0A0A0A);
    check_eq("rdw_beat1", 64'(rd[1]), 64'h0A0A0A0A);
    axi_read(16'h00A0, 8'd0, 3'd2, 2'd1, 4'h1, -1, 32'd0);
    check_eq("rdw_after", 64'(rd[0]), 64'h5A5A5A5A);

    // Reset in the middle of a write burst
    awid = 4'hC; awaddr = 16'h0080; awlen = 8'd3; awsize = 3'd2; awburst = 2'd1;
    awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'hF1; wstrb = 4'hF; wlast = 1'b0;
    @(negedge clk);
    wdata = 32'hF2;
    @(negedge clk);
    wvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_awready", 64'(awready), 64'(0));
    check_eq("mid_rst_wready", 64'(wready), 64'(0));
    check_eq("mid_rst_bvalid", 64'(bvalid), 64'(0));
    check_eq("mid_rst_arready", 64'(arready), 64'(0));
    check_eq("mid_rst_bid", 64'(bid), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_awready_after", 64'(awready), 64'(1));
    check_eq("mid_rst_wready_after", 64'(wready), 64'(0));
    prep(1, 32'hD1);
    axi_write(16'h0080, 8'd1, 3'd2, 2'd1, 4'hD, resp, bid_got);
    check_eq("post_rst_bresp", 64'(resp), 64'(0));
    check_eq("post_rst_bid", 64'(bid_got), 64'hD);
    axi_read(16'h0080, 8'd1, 3'd2, 2'd1, 4'hD, -1, 32'd0);
    check_eq("post_rst_rdata0", 64'(rd[0]), 64'hD1);
    check_eq("post_rst_rdata1", 64'(rd[1]), 64'hD2);
    check_eq("post_rst_rlast", 64'(rl[1]), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
